// File: rtl/div_op_sequencer.sv
// Divider self-test initiator: issues a table of operand pairs over a start/valid
// handshake, checks quot*Y+rem==X and rem<Y, and keeps pass/fail/skip counts.
module div_op_sequencer #(
  parameter int WIDTH   = 4,
  parameter int NUM_OPS = 6,
  parameter int TIMEOUT = 2*WIDTH+8,
  localparam int AW = $clog2(NUM_OPS),
  localparam int CW = $clog2(NUM_OPS+1),
  localparam int TW = $clog2(TIMEOUT+1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_x,
  input  logic [WIDTH-1:0] wr_y,
  input  logic             go,
  output logic             div_start,
  output logic [WIDTH-1:0] div_x,
  output logic [WIDTH-1:0] div_y,
  input  logic             div_valid,
  input  logic [WIDTH-1:0] div_quot,
  input  logic [WIDTH-1:0] div_rem,
  output logic             busy,
  output logic             done,
  output logic [CW-1:0]    pass_count,
  output logic [CW-1:0]    fail_count,
  output logic [CW-1:0]    skip_count,
  output logic [AW-1:0]    last_fail_idx,
  output logic             timeout_err,
  output logic [2:0]       dbg_state
);

  // Handshake: div_start is a single-cycle pulse with div_x/div_y valid in that
  // cycle and held until the next start; a result is accepted only on a 0->1
  // transition of div_valid seen after the start, so a level left high by the
  // previous operation never completes the new one.

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_CHECK = 3'd3,
    S_GAP   = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t state, state_nxt;

  logic [WIDTH-1:0] tab_x [NUM_OPS];
  logic [WIDTH-1:0] tab_y [NUM_OPS];

  logic [AW-1:0]    idx;
  logic [TW-1:0]    timer;
  logic             valid_q;
  logic [WIDTH-1:0] x_hold, y_hold, quot_q, rem_q;

  logic [WIDTH-1:0] cur_x, cur_y;
  logic             cur_skip, last_entry, valid_rise, timer_expired, result_ok;
  logic [2*WIDTH:0] prod, recon;

  assign cur_x         = tab_x[idx];
  assign cur_y         = tab_y[idx];
  assign cur_skip      = (cur_y == '0);
  assign last_entry    = (idx == AW'(NUM_OPS-1));
  assign valid_rise    = div_valid && !valid_q;
  assign timer_expired = (timer == TW'(TIMEOUT-1));

  // Reconstruction is done one bit wider than the product so the add cannot wrap.
  assign prod      = {{(WIDTH+1){1'b0}}, quot_q} * {{(WIDTH+1){1'b0}}, y_hold};
  assign recon     = prod + {{(WIDTH+1){1'b0}}, rem_q};
  assign result_ok = (recon == {{(WIDTH+1){1'b0}}, x_hold}) && (rem_q < y_hold);

  assign busy      = (state == S_ISSUE) || (state == S_WAIT) ||
                     (state == S_CHECK) || (state == S_GAP);
  assign done      = (state == S_DONE);
  assign dbg_state = state;
  assign div_x     = div_start ? cur_x : x_hold;
  assign div_y     = div_start ? cur_y : y_hold;

  // Table has no reset so contents survive rst.
  always_ff @(posedge clk) begin
    if (wr_en && !busy && (int'(wr_addr) < NUM_OPS)) begin
      tab_x[wr_addr] <= wr_x;
      tab_y[wr_addr] <= wr_y;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    div_start = 1'b0;
    case (state)
      S_IDLE:  if (go) state_nxt = S_ISSUE;
      S_ISSUE: begin
        if (cur_skip) begin
          state_nxt = last_entry ? S_DONE : S_ISSUE;
        end else begin
          div_start = 1'b1;
          state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (valid_rise)         state_nxt = S_CHECK;
        else if (timer_expired) state_nxt = S_DONE;
      end
      S_CHECK: state_nxt = S_GAP;
      S_GAP:   state_nxt = last_entry ? S_DONE : S_ISSUE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx           <= '0;
      timer         <= '0;
      valid_q       <= 1'b0;
      x_hold        <= '0;
      y_hold        <= '0;
      quot_q        <= '0;
      rem_q         <= '0;
      pass_count    <= '0;
      fail_count    <= '0;
      skip_count    <= '0;
      last_fail_idx <= '0;
      timeout_err   <= 1'b0;
    end else begin
      valid_q <= div_valid;
      case (state)
        S_IDLE: begin
          if (go) begin
            idx           <= '0;
            pass_count    <= '0;
            fail_count    <= '0;
            skip_count    <= '0;
            last_fail_idx <= '0;
            timeout_err   <= 1'b0;
          end
        end
        S_ISSUE: begin
          if (cur_skip) begin
            if (skip_count != CW'(NUM_OPS)) skip_count <= skip_count + 1'b1;
            if (!last_entry) idx <= idx + 1'b1;
          end else begin
            x_hold <= cur_x;
            y_hold <= cur_y;
            timer  <= '0;
          end
        end
        S_WAIT: begin
          if (valid_rise) begin
            quot_q <= div_quot;
            rem_q  <= div_rem;
          end else if (timer_expired) begin
            timeout_err <= 1'b1;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        S_CHECK: begin
          if (result_ok) begin
            if (pass_count != CW'(NUM_OPS)) pass_count <= pass_count + 1'b1;
          end else begin
            if (fail_count != CW'(NUM_OPS)) fail_count <= fail_count + 1'b1;
            last_fail_idx <= idx;
          end
        end
        S_GAP: begin
          if (!last_entry) idx <= idx + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div_op_sequencer.sv
// Bench for div_op_sequencer: behavioural divider model with fault modes,
// operand scoreboard on every start, and per-run result expectations.
module tb_div_op_sequencer;
  localparam int WIDTH   = 4;
  localparam int NUM_OPS = 6;
  localparam int TIMEOUT = 2*WIDTH+8;
  localparam int AW      = 3;
  localparam int CW      = 3;
  localparam int LAT     = 5;
  localparam int M_NORM  = 0;
  localparam int M_BAD   = 1;
  localparam int M_DEAD  = 2;
  localparam int M_HOLD  = 3;

  typedef struct packed {
    logic [CW-1:0] p;
    logic [CW-1:0] f;
    logic [CW-1:0] s;
    logic [AW-1:0] l;
    logic          t;
  } res_t;

  logic             clk = 1'b0;
  logic             rst, wr_en, go;
  logic [AW-1:0]    wr_addr;
  logic [WIDTH-1:0] wr_x, wr_y;
  logic             div_start, div_valid, busy, done, timeout_err;
  logic [WIDTH-1:0] div_x, div_y;
  logic [WIDTH-1:0] div_quot = '0;
  logic [WIDTH-1:0] div_rem  = '0;
  logic [CW-1:0]    pass_count, fail_count, skip_count;
  logic [AW-1:0]    last_fail_idx;
  logic [2:0]       dbg_state;

  int total = 0;
  int bad   = 0;
  int mode  = M_NORM;
  int cyc   = 0;
  int done_cnt = 0;
  int start_cnt = 0;
  int last_start_cyc = 0;

  logic [2*WIDTH-1:0] exp_q[$];
  res_t               res_q[$];
  logic [WIDTH-1:0]   tb_x [NUM_OPS];
  logic [WIDTH-1:0]   tb_y [NUM_OPS];

  div_op_sequencer #(.WIDTH(WIDTH), .NUM_OPS(NUM_OPS), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_x(wr_x), .wr_y(wr_y),
    .go(go), .div_start(div_start), .div_x(div_x), .div_y(div_y),
    .div_valid(div_valid), .div_quot(div_quot), .div_rem(div_rem),
    .busy(busy), .done(done), .pass_count(pass_count), .fail_count(fail_count),
    .skip_count(skip_count), .last_fail_idx(last_fail_idx),
    .timeout_err(timeout_err), .dbg_state(dbg_state)
  );

  // clock / reset block
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, total=%0d", total);
    $fatal(1, "watchdog");
  end

  // divider model: fixed latency; M_BAD corrupts rem of the third result,
  // M_DEAD never answers, M_HOLD keeps valid high across the next start
  logic             pend = 1'b0;
  int               cnt  = 0;
  int               op_n = 0;
  logic [WIDTH-1:0] mx = '0, my = '0;

  always @(posedge clk) begin
    if (rst) begin
      div_valid <= 1'b0;
      pend      <= 1'b0;
      cnt       <= 0;
      op_n      <= 0;
    end else begin
      if (go) op_n <= 0;
      if (div_start) begin
        mx   <= div_x;
        my   <= div_y;
        pend <= 1'b1;
        cnt  <= 0;
        if (mode != M_HOLD) div_valid <= 1'b0;
      end else if (pend) begin
        cnt <= cnt + 1;
        if (mode == M_HOLD && cnt == 1) div_valid <= 1'b0;
        if (cnt == LAT-1 && mode != M_DEAD) begin
          pend      <= 1'b0;
          div_valid <= 1'b1;
          op_n      <= op_n + 1;
          div_quot  <= (my == 0) ? '1 : WIDTH'(mx / my);
          div_rem   <= (my == 0) ? mx :
                       ((mode == M_BAD && op_n == 2) ? WIDTH'(mx % my + 1) : WIDTH'(mx % my));
        end
      end
    end
  end

  // operand scoreboard: every start must match the next expected pair
  always @(negedge clk) begin
    logic [2*WIDTH-1:0] e;
    if (done) done_cnt++;
    if (div_start) begin
      start_cnt++;
      last_start_cyc = cyc;
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL start_unexpected: got x=%0d y=%0d, required no start", div_x, div_y);
      end else begin
        e = exp_q.pop_front();
        if ({div_x, div_y} !== e) begin
          bad++;
          $display("FAIL start_operands: got x=%0d y=%0d, required x=%0d y=%0d",
                   div_x, div_y, e[2*WIDTH-1:WIDTH], e[WIDTH-1:0]);
        end
      end
    end
  end

  // driver tasks
  task automatic write_entry(input int a, input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
    @(negedge clk);
    wr_en = 1'b1; wr_addr = AW'(a); wr_x = x; wr_y = y;
    tb_x[a] = x; tb_y[a] = y;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic load_table();
    write_entry(0, 4'd15, 4'd8);
    write_entry(1, 4'd10, 4'd5);
    write_entry(2, 4'd8,  4'd4);
    write_entry(3, 4'd1,  4'd1);
    write_entry(4, 4'd15, 4'd1);
    write_entry(5, 4'd15, 4'd2);
  endtask

  task automatic push_starts(input int n);
    int k = 0;
    for (int i = 0; i < NUM_OPS; i++) begin
      if (tb_y[i] != 0 && k < n) begin
        exp_q.push_back({tb_x[i], tb_y[i]});
        k++;
      end
    end
  endtask

  function automatic res_t predict(input int bad_entry);
    res_t r = '0;
    for (int i = 0; i < NUM_OPS; i++) begin
      if (tb_y[i] == 0) r.s = r.s + 1'b1;
      else if (i == bad_entry) begin r.f = r.f + 1'b1; r.l = AW'(i); end
      else r.p = r.p + 1'b1;
    end
    return r;
  endfunction

  task automatic pulse_go();
    @(negedge clk); go = 1'b1;
    @(negedge clk); go = 1'b0;
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (done) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      total++; bad++;
      $display("FAIL done_wait: got no done pulse within 1000 cycles, required one");
    end
  endtask

  function automatic res_t observed();
    return '{p: pass_count, f: fail_count, s: skip_count, l: last_fail_idx, t: timeout_err};
  endfunction

  // tests
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if ({busy, done, div_start, dbg_state} !== 6'b0) begin
      bad++; $display("FAIL reset_ctrl: got busy=%b done=%b start=%b state=%0d, required all 0",
                      busy, done, div_start, dbg_state);
    end
    total++;
    if (observed() !== res_t'(0)) begin
      bad++; $display("FAIL reset_counts: got %h, required 0", observed());
    end
    total++;
    if ({div_x, div_y} !== 8'h00) begin
      bad++; $display("FAIL reset_operands: got x=%0d y=%0d, required 0", div_x, div_y);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_normal();
    bit ok; res_t e;
    mode = M_NORM;
    load_table();
    push_starts(NUM_OPS);
    res_q.push_back(predict(-1));
    done_cnt = 0;
    pulse_go();
    total++;
    if (busy !== 1'b1) begin bad++; $display("FAIL normal_busy: got %b, required 1", busy); end
    wait_done(ok);
    e = res_q.pop_front();
    if (ok) begin
      total++;
      if (observed() !== e) begin bad++; $display("FAIL normal_result: got %h, required %h", observed(), e); end
    end
    repeat (4) @(negedge clk);
    total++;
    if (done_cnt !== 1) begin bad++; $display("FAIL normal_done_once: got %0d pulses, required 1", done_cnt); end
    total++;
    if (observed() !== e || busy !== 1'b0) begin
      bad++; $display("FAIL normal_hold: got %h busy=%b, required %h busy=0", observed(), busy, e);
    end
    total++;
    if (exp_q.size() != 0) begin bad++; $display("FAIL normal_starts_left: got %0d, required 0", exp_q.size()); end
  endtask

  task automatic test_busy_ignore();
    bit ok; res_t e;
    mode = M_NORM;
    push_starts(NUM_OPS);
    res_q.push_back(predict(-1));
    done_cnt = 0;
    pulse_go();
    repeat (4) @(negedge clk);
    go = 1'b1; wr_en = 1'b1; wr_addr = 3'd5; wr_x = 4'd9; wr_y = 4'd0;
    @(negedge clk);
    go = 1'b0; wr_en = 1'b0;
    wait_done(ok);
    e = res_q.pop_front();
    if (ok) begin
      total++;
      if (observed() !== e) begin bad++; $display("FAIL busy_ignore_result: got %h, required %h", observed(), e); end
    end
    repeat (3) @(negedge clk);
    total++;
    if (done_cnt !== 1) begin bad++; $display("FAIL busy_ignore_done: got %0d pulses, required 1", done_cnt); end
  endtask

  task automatic test_bad_rem();
    bit ok; res_t e;
    mode = M_BAD;
    push_starts(NUM_OPS);
    res_q.push_back(predict(2));
    pulse_go();
    wait_done(ok);
    e = res_q.pop_front();
    if (ok) begin
      total++;
      if (observed() !== e) begin bad++; $display("FAIL bad_rem_result: got %h, required %h", observed(), e); end
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_skip();
    bit ok; res_t e;
    mode = M_NORM;
    @(negedge clk);
    go = 1'b1; wr_en = 1'b1; wr_addr = 3'd3; wr_x = 4'd7; wr_y = 4'd0;
    tb_x[3] = 4'd7; tb_y[3] = 4'd0;
    push_starts(NUM_OPS);
    res_q.push_back(predict(-1));
    @(negedge clk);
    go = 1'b0; wr_en = 1'b0;
    wait_done(ok);
    e = res_q.pop_front();
    if (ok) begin
      total++;
      if (observed() !== e) begin bad++; $display("FAIL skip_result: got %h, required %h", observed(), e); end
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_timeout();
    bit ok; res_t e; int dcyc;
    write_entry(3, 4'd1, 4'd1);
    mode = M_DEAD;
    push_starts(1);
    res_q.push_back('{p: 0, f: 0, s: 0, l: 0, t: 1'b1});
    done_cnt = 0;
    pulse_go();
    wait_done(ok);
    dcyc = cyc;
    e = res_q.pop_front();
    if (ok) begin
      total++;
      if (observed() !== e) begin bad++; $display("FAIL timeout_result: got %h, required %h", observed(), e); end
      total++;
      if (dcyc - last_start_cyc != TIMEOUT+1) begin
        bad++; $display("FAIL timeout_latency: got %0d cycles, required %0d", dcyc - last_start_cyc, TIMEOUT+1);
      end
    end
    repeat (5) @(negedge clk);
    total++;
    if (done_cnt !== 1 || timeout_err !== 1'b1) begin
      bad++; $display("FAIL timeout_sticky: got done=%0d err=%b, required 1 and 1", done_cnt, timeout_err);
    end
  endtask

  task automatic test_hold_valid();
    bit ok; res_t e;
    mode = M_HOLD;
    push_starts(NUM_OPS);
    res_q.push_back(predict(-1));
    pulse_go();
    wait_done(ok);
    e = res_q.pop_front();
    if (ok) begin
      total++;
      if (observed() !== e) begin bad++; $display("FAIL hold_valid_result: got %h, required %h", observed(), e); end
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_rst_mid();
    bit ok; bit hit; res_t e;
    mode = M_NORM;
    push_starts(NUM_OPS);
    start_cnt = 0;
    pulse_go();
    hit = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (start_cnt >= 3) begin hit = 1'b1; break; end
      @(negedge clk);
    end
    total++;
    if (!hit) begin bad++; $display("FAIL rst_mid_reach: got %0d starts, required 3", start_cnt); end
    repeat (2) @(negedge clk);
    total++;
    if (pass_count !== 3'd2) begin bad++; $display("FAIL rst_mid_pre: got pass=%0d, required 2", pass_count); end
    rst = 1'b1;
    @(negedge clk);
    total++;
    if (busy !== 1'b0 || div_start !== 1'b0 || dbg_state !== 3'd0 || observed() !== res_t'(0)) begin
      bad++; $display("FAIL rst_mid_clear: got busy=%b start=%b state=%0d counts=%h, required all 0",
                      busy, div_start, dbg_state, observed());
    end
    rst = 1'b0;
    exp_q.delete();
    push_starts(NUM_OPS);
    res_q.push_back(predict(-1));
    done_cnt = 0;
    pulse_go();
    wait_done(ok);
    e = res_q.pop_front();
    if (ok) begin
      total++;
      if (observed() !== e) begin bad++; $display("FAIL rst_mid_rerun: got %h, required %h", observed(), e); end
    end
    repeat (3) @(negedge clk);
    total++;
    if (done_cnt !== 1) begin bad++; $display("FAIL rst_mid_done: got %0d pulses, required 1", done_cnt); end
  endtask

  initial begin
    rst = 1'b1; wr_en = 1'b0; go = 1'b0; wr_addr = '0; wr_x = '0; wr_y = '0;
    test_reset();
    test_normal();
    test_busy_ignore();
    test_bad_rem();
    test_skip();
    test_timeout();
    test_hold_valid();
    test_rst_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
